// File: rtl/cache_ctrl.sv
// Direct-mapped, one-word-per-line, write-through / no-write-allocate cache controller.
// Optional hit/miss statistics counters are enabled with `define CACHE_STATS_EN.
module cache_ctrl #(
  parameter int unsigned ADDR_WIDTH    = 8,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned LINES         = 8,
  parameter int unsigned UNCACHED_BASE = 128
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic                  cpu_ready,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ready
`ifdef CACHE_STATS_EN
  ,
  output logic [15:0]           hit_count,
  output logic [15:0]           miss_count
`endif
);

  localparam int unsigned INDEX_BITS = $clog2(LINES);
  localparam int unsigned TAG_W      = ADDR_WIDTH - INDEX_BITS;
  localparam int unsigned AW1        = ADDR_WIDTH + 1;

  typedef enum logic [2:0] {IDLE, LOOKUP, MEM_RD, MEM_WR, RESP} state_t;

  state_t                  r_state;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic                    r_we;
  logic [DATA_WIDTH-1:0]   r_wdata;
  logic [LINES-1:0]        r_valid;
  logic [TAG_W-1:0]        r_tag  [LINES];
  logic [DATA_WIDTH-1:0]   r_data [LINES];
  logic [DATA_WIDTH-1:0]   r_cpu_rdata;
  logic                    r_cpu_ready;
  logic                    r_mem_req;
  logic                    r_mem_we;
  logic [ADDR_WIDTH-1:0]   r_mem_addr;
  logic [DATA_WIDTH-1:0]   r_mem_wdata;
`ifdef CACHE_STATS_EN
  logic [15:0]             r_hit_count;
  logic [15:0]             r_miss_count;
`endif

  logic [INDEX_BITS-1:0]   w_index;
  logic [TAG_W-1:0]        w_tag;
  logic                    w_cacheable;
  logic                    w_hit;
  logic                    w_line_wr;
  logic [DATA_WIDTH-1:0]   w_line_data;

  // Lookup decode on the latched address
  assign w_index     = r_addr[INDEX_BITS-1:0];
  assign w_tag       = r_addr[ADDR_WIDTH-1:INDEX_BITS];
  assign w_cacheable = ({1'b0, r_addr} < AW1'(UNCACHED_BASE));
  assign w_hit       = w_cacheable && r_valid[w_index] && (r_tag[w_index] == w_tag);

  // Line written on a write hit (LOOKUP) or a cacheable refill (MEM_RD completion)
  assign w_line_wr   = ((r_state == LOOKUP) && r_we && w_hit) ||
                       ((r_state == MEM_RD) && mem_ready && w_cacheable);
  assign w_line_data = (r_state == LOOKUP) ? r_wdata : mem_rdata;

  always_ff @(posedge clk) begin
    if (w_line_wr) begin
      r_data[w_index] <= w_line_data;
      r_tag[w_index]  <= w_tag;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_addr       <= '0;
      r_we         <= 1'b0;
      r_wdata      <= '0;
      r_valid      <= '0;
      r_cpu_rdata  <= '0;
      r_cpu_ready  <= 1'b0;
      r_mem_req    <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
`ifdef CACHE_STATS_EN
      r_hit_count  <= '0;
      r_miss_count <= '0;
`endif
    end else begin
      r_cpu_ready <= 1'b0;
      case (r_state)
        IDLE: begin
          if (cpu_req) begin
            r_addr  <= cpu_addr;
            r_we    <= cpu_we;
            r_wdata <= cpu_wdata;
            r_state <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (r_we) begin
            r_mem_req   <= 1'b1;
            r_mem_we    <= 1'b1;
            r_mem_addr  <= r_addr;
            r_mem_wdata <= r_wdata;
            r_state     <= MEM_WR;
          end else if (w_hit) begin
            r_cpu_rdata <= r_data[w_index];
            r_cpu_ready <= 1'b1;
            r_state     <= RESP;
`ifdef CACHE_STATS_EN
            if (r_hit_count != 16'hFFFF) r_hit_count <= r_hit_count + 16'd1;
`endif
          end else begin
            r_mem_req  <= 1'b1;
            r_mem_we   <= 1'b0;
            r_mem_addr <= r_addr;
            r_state    <= MEM_RD;
`ifdef CACHE_STATS_EN
            if (w_cacheable && (r_miss_count != 16'hFFFF)) r_miss_count <= r_miss_count + 16'd1;
`endif
          end
        end
        MEM_RD: begin
          if (mem_ready) begin
            r_cpu_rdata <= mem_rdata;
            if (w_cacheable) r_valid[w_index] <= 1'b1;
            r_mem_req   <= 1'b0;
            r_cpu_ready <= 1'b1;
            r_state     <= RESP;
          end
        end
        MEM_WR: begin
          if (mem_ready) begin
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_cpu_ready <= 1'b1;
            r_state     <= RESP;
          end
        end
        RESP:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign cpu_rdata = r_cpu_rdata;
  assign cpu_ready = r_cpu_ready;
  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
`ifdef CACHE_STATS_EN
  assign hit_count  = r_hit_count;
  assign miss_count = r_miss_count;
`endif

endmodule

// File: tb/tb_cache_ctrl.sv
// Directed bench for cache_ctrl: hit/miss latency, write-through, uncached region,
// mid-transaction reset and (with CACHE_STATS_EN) counter behaviour.
module tb_cache_ctrl;

  logic        clk;
  logic        rst_n;
  logic        cpu_req;
  logic        cpu_we;
  logic [7:0]  cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_ready;
  logic        mem_req;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;
`ifdef CACHE_STATS_EN
  logic [15:0] hit_count;
  logic [15:0] miss_count;
`endif

  int checks   = 0;
  int failures = 0;

  logic [31:0] mem_model [256];
  int          mem_wait  = 2;
  int          wcnt      = 0;
  int          mem_txns  = 0;
  logic        last_we;
  logic [7:0]  last_addr;
  logic [31:0] last_wdata;

  cache_ctrl #(
    .ADDR_WIDTH(8), .DATA_WIDTH(32), .LINES(8), .UNCACHED_BASE(128)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
`ifdef CACHE_STATS_EN
    , .hit_count(hit_count), .miss_count(miss_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Backing memory: answers mem_req after mem_wait wait cycles with a one-cycle mem_ready
  initial begin
    mem_ready = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        mem_ready = 1'b0;
        wcnt      = 0;
      end else if (mem_req && !mem_ready) begin
        if (wcnt == mem_wait) begin
          mem_ready  = 1'b1;
          mem_rdata  = mem_model[mem_addr];
          last_we    = mem_we;
          last_addr  = mem_addr;
          last_wdata = mem_wdata;
          if (mem_we) mem_model[mem_addr] = mem_wdata;
          mem_txns++;
          wcnt = 0;
        end else begin
          wcnt++;
        end
      end else begin
        mem_ready = 1'b0;
      end
    end
  end

  // One CPU access; returns cycles from the request-sampling edge to cpu_ready
  task automatic cpu_access(input logic we, input logic [7:0] addr, input logic [31:0] wd,
                            output int lat);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
    lat = 0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      lat++;
      if (cpu_ready) break;
    end
    cpu_req = 1'b0;
    @(posedge clk); #1;
    chk("ready_pulse", 32'(cpu_ready), 32'd0);
  endtask

  task automatic rd(input string tag, input logic [7:0] addr, input logic [31:0] exp_data,
                    input int exp_lat, input int exp_txn);
    int lat;
    int t0;
    t0 = mem_txns;
    cpu_access(1'b0, addr, 32'd0, lat);
    chk({tag, "_lat"},  32'(lat), 32'(exp_lat));
    chk({tag, "_data"}, cpu_rdata, exp_data);
    chk({tag, "_txn"},  32'(mem_txns - t0), 32'(exp_txn));
  endtask

  task automatic wr(input string tag, input logic [7:0] addr, input logic [31:0] data,
                    input int exp_lat);
    int lat;
    int t0;
    t0 = mem_txns;
    cpu_access(1'b1, addr, data, lat);
    chk({tag, "_lat"},   32'(lat), 32'(exp_lat));
    chk({tag, "_txn"},   32'(mem_txns - t0), 32'd1);
    chk({tag, "_we"},    32'(last_we), 32'd1);
    chk({tag, "_addr"},  32'(last_addr), 32'(addr));
    chk({tag, "_wdata"}, last_wdata, data);
  endtask

  task automatic stats(input string tag, input int exp_hit, input int exp_miss);
`ifdef CACHE_STATS_EN
    chk({tag, "_hits"},   32'(hit_count),  32'(exp_hit));
    chk({tag, "_misses"}, 32'(miss_count), 32'(exp_miss));
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int stuck;
    for (int i = 0; i < 256; i++) mem_model[i] = 32'd0;
    mem_model[8'h05] = 32'hDEADBEEF;
    mem_model[8'h0D] = 32'hCAFEF00D;
    mem_model[8'h80] = 32'hA5A5A5A5;
    mem_model[8'h06] = 32'h00660066;
    mem_model[8'h07] = 32'h00770077;
    rst_n = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 32'(cpu_ready), 32'd0);
    chk("rst_rdata", cpu_rdata, 32'd0);
    chk("rst_mreq",  32'(mem_req), 32'd0);
    chk("rst_maddr", 32'(mem_addr), 32'd0);
    stats("rst", 0, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    rd("cold05", 8'h05, 32'hDEADBEEF, 5, 1);
    chk("cold05_maddr", 32'(last_addr), 32'h05);
    stats("cold05", 0, 1);
    rd("hit05", 8'h05, 32'hDEADBEEF, 2, 0);
    stats("hit05", 1, 1);

    wr("wr05", 8'h05, 32'h12345678, 5);
    chk("wr05_rdata_hold", cpu_rdata, 32'hDEADBEEF);
    rd("hit05b", 8'h05, 32'h12345678, 2, 0);
    rd("miss0d", 8'h0D, 32'hCAFEF00D, 5, 1);
    rd("evict05", 8'h05, 32'h12345678, 5, 1);
    stats("alias", 2, 3);

    rd("unc80a", 8'h80, 32'hA5A5A5A5, 5, 1);
    rd("unc80b", 8'h80, 32'hA5A5A5A5, 5, 1);
    stats("unc", 2, 3);

    wr("wr03", 8'h03, 32'h00000011, 5);
    rd("noalloc03", 8'h03, 32'h00000011, 5, 1);

    mem_wait = 0;
    rd("fast06", 8'h06, 32'h00660066, 3, 1);
    mem_wait = 2;
    stats("pre_rst", 2, 5);

    // Reset while MEM_RD is waiting on memory
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h07;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("midrst_mreq_hi", 32'(mem_req), 32'd1);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("midrst_mreq_lo", 32'(mem_req), 32'd0);
    chk("midrst_rdata", cpu_rdata, 32'd0);
    cpu_req = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    stuck = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (cpu_ready || mem_req) stuck++;
    end
    chk("midrst_quiet", 32'(stuck), 32'd0);
    stats("post_rst", 0, 0);
    rd("post_rst05", 8'h05, 32'h12345678, 5, 1);
    rd("post_rst07", 8'h07, 32'h00770077, 5, 1);
    rd("post_rst05h", 8'h05, 32'h12345678, 2, 0);
    stats("post_rst", 1, 2);

`ifdef CACHE_STATS_EN
    force dut.r_hit_count = 16'hFFFF;
    @(posedge clk); #1;
    release dut.r_hit_count;
    rd("sat05", 8'h05, 32'h12345678, 2, 0);
    stats("sat", 16'hFFFF, 2);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cache_ctrl.md
CACHE_CTRL -- requirements
Module: cache_ctrl

Interface
REQ-001 Parameters (name, default, meaning) SHALL be:
- ADDR_WIDTH, 8, word address width.
- DATA_WIDTH, 32, word width.
- LINES, 8, direct-mapped lines, power of two; INDEX_BITS = $clog2(LINES).
- UNCACHED_BASE, 128, addresses >= this bypass the cache (GPIO region).
REQ-002 Ports (name, direction, width, meaning) SHALL be:
- clk, in, 1, single clock, rising edge.
- rst_n, in, 1, reset; one clock, asynchronous active-low reset.
- cpu_req, in, 1, CPU access request, held until cpu_ready.
- cpu_we, in, 1, 1 = write.
- cpu_addr, in, ADDR_WIDTH, word address.
- cpu_wdata, in, DATA_WIDTH, write data.
- cpu_rdata, out, DATA_WIDTH, read data, valid with cpu_ready.
- cpu_ready, out, 1, one-cycle completion pulse.
- mem_req, out, 1, backing-memory request.
- mem_we, out, 1, memory write strobe.
- mem_addr, out, ADDR_WIDTH, memory address.
- mem_wdata, out, DATA_WIDTH, memory write data.
- mem_rdata, in, DATA_WIDTH, memory read data, valid with mem_ready.
- mem_ready, in, 1, memory completion, one cycle.

Function
REQ-003 Organisation SHALL be direct-mapped, one word per line, write-through, no-write-allocate; index = addr[INDEX_BITS-1:0], tag = addr[ADDR_WIDTH-1:INDEX_BITS].
REQ-004 FSM states SHALL be IDLE, LOOKUP, MEM_RD, MEM_WR, RESP.
REQ-005 IDLE: when cpu_req=1, latch cpu_addr/cpu_we/cpu_wdata and go to LOOKUP; cpu_req is ignored in every other state.
REQ-006 LOOKUP, read, cacheable, valid and tag match (hit): load cpu_rdata from the line and go to RESP.
REQ-007 LOOKUP, read miss or uncached read: go to MEM_RD.
REQ-008 LOOKUP, write: on a cacheable hit, update the line data in the same cycle; in all cases go to MEM_WR.
REQ-009 MEM_RD: hold mem_req=1, mem_we=0, mem_addr=latched address until mem_ready=1.
- On mem_ready, capture mem_rdata into cpu_rdata.
- If cacheable, fill the line (data, tag, valid=1).
- Go to RESP.
REQ-010 MEM_WR: hold mem_req=1, mem_we=1, mem_addr and mem_wdata = latched values until mem_ready=1, then go to RESP.
REQ-011 RESP: cpu_ready=1 for exactly one cycle, then go to IDLE.
REQ-012 Read-hit latency SHALL be 2 cycles: request sampled at edge N, cpu_ready high in cycle N+2.
REQ-013 Miss and write latency SHALL be 3 cycles plus memory wait cycles.
REQ-014 mem_ready while mem_req=0 SHALL be ignored; mem_req SHALL be low in IDLE, LOOKUP and RESP.
REQ-015 cpu_rdata SHALL hold its value until the next read completes; it is undefined after writes only if the bench reads it, and is otherwise unchanged by writes.
REQ-016 An uncached access SHALL never read or modify cache state.

Reset
REQ-017 rst_n low SHALL immediately (asynchronously) set:
- state = IDLE, all valid bits = 0;
- cpu_ready = 0, cpu_rdata = 0;
- mem_req = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0.
Tag and data arrays need not be reset.
REQ-018 Reset mid-transaction SHALL abandon the access with no cpu_ready and no line fill; a mem_ready arriving after reset is ignored.

Configuration
REQ-019 Macro CACHE_STATS_EN:
- Defined: adds outputs hit_count[15:0] and miss_count[15:0], reset to 0. Each increments by 1 per cacheable read hit or miss respectively, evaluated in LOOKUP, and saturates at 16'hFFFF. Writes and uncached reads are not counted.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Verification
REQ-020 Cold read 0x05: mem_req with mem_addr=0x05 appears; memory returns 0xDEADBEEF after 2 wait cycles -> cpu_rdata=0xDEADBEEF, cpu_ready 5 cycles after the request; miss_count=1.
REQ-021 Re-read 0x05 -> no mem_req, cpu_ready at N+2, cpu_rdata=0xDEADBEEF, hit_count=1.
REQ-022 Write 0x12345678 to 0x05, then read 0x05 -> mem write issued with mem_wdata=0x12345678; the read hits and returns 0x12345678. Read 0x0D (same index, different tag) -> miss and refill.
REQ-023 Read 0x80 twice -> both accesses issue mem_req; no hit; counters unchanged.
REQ-024 Assert rst_n=0 during MEM_RD wait -> mem_req drops in the same cycle; no cpu_ready; a later read of the same address misses.
REQ-025 With CACHE_STATS_EN, force hit_count to 0xFFFF and perform a read hit -> hit_count stays 0xFFFF.
